// File: rtl/mul_share_ctrl.sv
// Round-robin front end that shares one start/valid shift-add multiplier core
// among N requesters and returns each product tagged with its requester id.
module mul_share_ctrl #(
  parameter int N   = 4,
  parameter int IDW = 2,
  parameter int AW  = 8,
  parameter int BW  = 3,
  parameter int RW  = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*AW-1:0] req_a,
  input  logic [N*BW-1:0] req_b,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [RW-1:0]   rsp_result,
  output logic            mul_start,
  output logic [AW-1:0]   mul_a,
  output logic [BW-1:0]   mul_b,
  input  logic            mul_valid,
  input  logic [RW-1:0]   mul_result
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] cur;
  logic [IDW-1:0] win;
  logic           found;
  logic           issue;

  // First pending requester at or above the pointer, wrapping modulo N.
  always_comb begin
    int k;
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!found && req[k]) begin
        found = 1'b1;
        win   = IDW'(k);
      end
    end
  end

  // The core has no reset, so an issue always waits for its valid flag,
  // including right after rst while an abandoned operation is still counting.
  assign issue = (state == IDLE) && mul_valid && found && !rst;

  always_comb begin
    gnt       = '0;
    mul_start = issue;
    mul_a     = '0;
    mul_b     = '0;
    if (issue) begin
      gnt[win] = 1'b1;
      mul_a    = req_a[int'(win)*AW +: AW];
      mul_b    = req_b[int'(win)*BW +: BW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      cur        <= '0;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            cur   <= win;
            ptr   <= (win == IDW'(N-1)) ? '0 : win + 1'b1;
            state <= WAIT;
            busy  <= 1'b1;
          end
        end
        WAIT: begin
          if (mul_valid) begin
            rsp_result <= mul_result;
            rsp_id     <= cur;
            rsp_valid  <= 1'b1;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural repeated-add core that
// takes b cycles and drops valid the cycle after start.
module tb_mul_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_a;
  logic [11:0] req_b;
  logic [3:0]  gnt;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [10:0] rsp_result;
  logic        mul_start;
  logic [7:0]  mul_a;
  logic [2:0]  mul_b;
  logic        mul_valid;
  logic [10:0] mul_result;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_share_ctrl #(.N(4), .IDW(2), .AW(8), .BW(3), .RW(11)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .mul_start(mul_start), .mul_a(mul_a),
    .mul_b(mul_b), .mul_valid(mul_valid), .mul_result(mul_result)
  );

  // Core model: no reset; accumulates a once per cycle for b cycles.
  logic [2:0]  core_cnt = '0;
  logic [10:0] core_acc = '0;
  logic [7:0]  core_a   = '0;
  always @(posedge clk) begin
    if (mul_start) begin
      core_cnt <= mul_b;
      core_acc <= '0;
      core_a   <= mul_a;
    end else if (core_cnt != 0) begin
      core_acc <= core_acc + 11'(core_a);
      core_cnt <= core_cnt - 3'd1;
    end
  end
  assign mul_valid  = (core_cnt == 3'd0);
  assign mul_result = core_acc;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [2:0] b);
    req_a[i*8 +: 8] = a;
    req_b[i*3 +: 3] = b;
    req[i]          = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge of the first cycle with a grant.
  task automatic wait_gnt(output int n);
    n = 0;
    while (gnt == 4'b0 && n < 40) begin
      step;
      @(negedge clk);
      n++;
    end
  endtask

  // Called at a negedge; drops 'drop' at the next edge, returns at the
  // negedge of the response cycle (or after 40 cycles).
  task automatic wait_rsp(input logic [3:0] drop, output int n);
    n = 0;
    do begin
      step;
      if (n == 0) req = req & ~drop;
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 40);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 4'b1111; req_a = '0; req_b = '0;
    step; step;
    @(negedge clk);
    checks++;
    if ({busy, rsp_valid, rsp_id, rsp_result} !== 15'd0) begin
      failures++;
      $display("FAIL reset_rsp got busy=%0b valid=%0b id=%0d result=%0d exp all 0",
               busy, rsp_valid, rsp_id, rsp_result);
    end
    checks++;
    if ({gnt, mul_start, mul_a, mul_b} !== 16'd0) begin
      failures++;
      $display("FAIL reset_issue got gnt=%b start=%0b a=%0d b=%0d exp all 0",
               gnt, mul_start, mul_a, mul_b);
    end
    step;
    req = 4'b0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int bad;
    bad = 0;
    step;
    set_op(1, 8'd13, 3'd5);
    @(negedge clk);
    checks++;
    if ({gnt, mul_start, mul_a, mul_b} !== {4'b0010, 1'b1, 8'd13, 3'd5}) begin
      failures++;
      $display("FAIL single_issue got gnt=%b start=%0b a=%0d b=%0d exp 0010 1 13 5",
               gnt, mul_start, mul_a, mul_b);
    end
    for (int c = 1; c <= 6; c++) begin
      step;
      if (c == 1) req = 4'b0;
      @(negedge clk);
      if (!busy || rsp_valid || mul_start || mul_a != 8'd0 || mul_b != 3'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL single_busy got %0d bad cycles exp 0", bad);
    end
    step;
    @(negedge clk);
    checks++;
    if ({rsp_valid, busy, rsp_id, rsp_result} !== {1'b1, 1'b0, 2'd1, 11'd65}) begin
      failures++;
      $display("FAIL single_rsp got valid=%0b busy=%0b id=%0d result=%0d exp 1 0 1 65",
               rsp_valid, busy, rsp_id, rsp_result);
    end
  endtask

  task automatic test_zero_b;
    int n;
    step;
    set_op(0, 8'd200, 3'd0);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL zero_gnt got %b exp 0001", gnt);
    end
    step;
    req = 4'b0;
    @(negedge clk);
    step;
    set_op(3, 8'd3, 3'd1);
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, gnt} !== {1'b1, 2'd0, 11'd0, 4'b1000}) begin
      failures++;
      $display("FAIL zero_rsp got valid=%0b id=%0d result=%0d gnt=%b exp 1 0 0 1000",
               rsp_valid, rsp_id, rsp_result, gnt);
    end
    wait_rsp(4'b1000, n);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, 6'(n)} !== {1'b1, 2'd3, 11'd3, 6'd3}) begin
      failures++;
      $display("FAIL back_to_back got valid=%0b id=%0d result=%0d lat=%0d exp 1 3 3 3",
               rsp_valid, rsp_id, rsp_result, n);
    end
  endtask

  task automatic test_max;
    int early, n;
    early = 0;
    step;
    set_op(2, 8'd255, 3'd7);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      failures++;
      $display("FAIL max_gnt got %b exp 0100", gnt);
    end
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c == 1) begin
        req = 4'b0;
        set_op(1, 8'd10, 3'd1);
      end
      @(negedge clk);
      if (gnt != 4'b0 || rsp_valid) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL max_early got %0d early events exp 0", early);
    end
    step;
    @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, gnt} !== {1'b1, 2'd2, 11'd1785, 4'b0010}) begin
      failures++;
      $display("FAIL max_rsp got valid=%0b id=%0d result=%0d gnt=%b exp 1 2 1785 0010",
               rsp_valid, rsp_id, rsp_result, gnt);
    end
    wait_rsp(4'b0010, n);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 2'd1, 11'd10}) begin
      failures++;
      $display("FAIL max_next got valid=%0b id=%0d result=%0d exp 1 1 10",
               rsp_valid, rsp_id, rsp_result);
    end
  endtask

  task automatic test_contention;
    logic [7:0]  a_tab [4] = '{8'd11, 8'd22, 8'd33, 8'd44};
    logic [2:0]  b_tab [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [10:0] p_tab [4] = '{11'd11, 11'd44, 11'd99, 11'd176};
    logic [3:0]  onehot;
    int n;
    step;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, a_tab[i], b_tab[i]);
    step;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      onehot = 4'b0001 << k;
      wait_gnt(n);
      checks++;
      if (gnt !== onehot) begin
        failures++;
        $display("FAIL contention_gnt%0d got %b exp %b", k, gnt, onehot);
      end
      wait_rsp(onehot, n);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result, 6'(n)} !== {1'b1, 2'(k), p_tab[k], 6'(b_tab[k]) + 6'd2}) begin
        failures++;
        $display("FAIL contention_rsp%0d got valid=%0b id=%0d result=%0d lat=%0d exp 1 %0d %0d %0d",
                 k, rsp_valid, rsp_id, rsp_result, n, k, p_tab[k], b_tab[k] + 2);
      end
    end
  endtask

  task automatic test_fairness;
    logic [3:0]  g_exp [4] = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    logic [1:0]  i_exp [4] = '{2'd0, 2'd2, 2'd0, 2'd2};
    logic [10:0] r_exp [4] = '{11'd7, 11'd6, 11'd7, 11'd6};
    int n;
    step;
    set_op(0, 8'd7, 3'd1);
    set_op(2, 8'd6, 3'd1);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      wait_gnt(n);
      checks++;
      if (gnt !== g_exp[k]) begin
        failures++;
        $display("FAIL fair_gnt%0d got %b exp %b", k, gnt, g_exp[k]);
      end
      wait_rsp(4'b0, n);
      checks++;
      if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, i_exp[k], r_exp[k]}) begin
        failures++;
        $display("FAIL fair_rsp%0d got valid=%0b id=%0d result=%0d exp 1 %0d %0d",
                 k, rsp_valid, rsp_id, rsp_result, i_exp[k], r_exp[k]);
      end
    end
    wait_gnt(n);
    wait_rsp(4'b0101, n);
  endtask

  task automatic test_reset_mid;
    int rsp_seen, early, n;
    rsp_seen = 0;
    early    = 0;
    step;
    set_op(0, 8'd9, 3'd7);
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_gnt got %b exp 0001", gnt);
    end
    for (int c = 1; c <= 8; c++) begin
      step;
      if (c == 1) begin
        req = 4'b0;
        set_op(3, 8'd5, 3'd2);
      end
      if (c == 3) rst = 1'b1;
      if (c == 4) rst = 1'b0;
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
      if (c < 8 && (gnt != 4'b0 || mul_start)) early++;
    end
    checks++;
    if (rsp_seen !== 0) begin
      failures++;
      $display("FAIL rstmid_dropped got %0d responses exp 0", rsp_seen);
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL rstmid_early got %0d early grants exp 0", early);
    end
    checks++;
    if (gnt !== 4'b1000) begin
      failures++;
      $display("FAIL rstmid_regrant got %b exp 1000", gnt);
    end
    wait_rsp(4'b1000, n);
    checks++;
    if ({rsp_valid, rsp_id, rsp_result, 6'(n)} !== {1'b1, 2'd3, 11'd10, 6'd4}) begin
      failures++;
      $display("FAIL rstmid_rsp got valid=%0b id=%0d result=%0d lat=%0d exp 1 3 10 4",
               rsp_valid, rsp_id, rsp_result, n);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_zero_b;
    test_max;
    test_contention;
    test_fairness;
    test_reset_mid;
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
